tog_pulse_dec: RTL and testbench
================================

// Module: tog_pulse_dec
// PURPOSE
//   Receive end of the toggle-event link: a T flip-flop on the far side flips tog_in once per event.
//   This block synchronises tog_in into CLK, regenerates one event per toggle, and queues events in
//   a pending counter. Events drain through a valid/ready handshake and are tallied in a wrapping
//   event counter. Sits between any toggle-encoded source and the local control logic.
// PARAMETERS
//   SYNC_STAGES  2   flops in the tog_in synchroniser chain (legal 2..4)
//   PEND_W       3   width of pending-event counter; saturates at 2**PEND_W-1
//   CNT_W        8   width of evt_cnt; wraps modulo 2**CNT_W
// PORTS
//   CLK        in   1        clock, rising edge
//   rst        in   1        asynchronous, active-low reset
//   tog_in     in   1        toggle line from the far-side T flip-flop (asynchronous to CLK)
//   pulse_rdy  in   1        downstream ready to accept one event
//   pulse_vld  out  1        at least one event pending (= pend != 0)
//   pend       out  PEND_W   number of events pending
//   evt_cnt    out  CNT_W    total toggles detected since reset, wrapping
//   ovf        out  1        sticky: a toggle arrived while pend was saturated
//   armed      out  1        detector active (state ACTIVE)
//   clr        in   1        only when TOGDEC_CLR_EN defined (see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst=0, immediate): sync chain=0, prev=0, state=ARMING, arm count=0, pend=0, evt_cnt=0,
//     ovf=0; hence pulse_vld=0, armed=0. rst asserted mid-operation discards all pending events.
//   Synchroniser: s[0]<=tog_in, s[i]<=s[i-1]; prev<=s[SYNC_STAGES-1] every cycle.
//   det = (s[SYNC_STAGES-1] ^ prev) & (state==ACTIVE).
//   FSM: ARMING -> ACTIVE after SYNC_STAGES+1 rising edges following rst release; in ARMING prev
//     tracks the chain but no events are detected (a static tog_in=1 at reset is NOT an event).
//     ACTIVE persists until reset; no other transitions.
//   Handshake: take = pulse_vld & pulse_rdy. pulse_rdy ignored while pend==0.
//   pend next value:
//     det & !take: pend+1, unless pend==max -> pend holds, ovf<=1
//     !det & take: pend-1
//     det & take:  pend unchanged (even at max; no ovf)
//     neither:     unchanged
//   evt_cnt <= evt_cnt+1 on every det (including det while saturated), wraps max->0.
//   Latency: tog_in edge meeting setup before CLK edge k -> pend/pulse_vld update at edge
//     k+SYNC_STAGES (det combinational from chain output), visible cycle after.
//   Toggles closer together than 1 CLK period on tog_in may merge (even count lost); source must
//     hold each level >= 2 CLK periods. Not detected; documented limit.
//   All outputs registered except pulse_vld (decode of pend).
// CONFIGURATION
//   TOGDEC_CLR_EN defined: port clr present; clr=1 at a rising edge sets pend=0, evt_cnt=0, ovf=0
//     synchronously, overriding det/take that cycle; sync chain, prev and FSM unaffected.
//   Undefined: no clr port; counters cleared only by rst.
// TESTING
//   rst release with tog_in held 1, wait 10 cycles -> armed=1 after 3 edges, pend=0, evt_cnt=0.
//   ACTIVE, pulse_rdy=0, tog_in toggles 3x every 4 cycles -> pend=3, evt_cnt=3, pulse_vld=1,
//     first pend increment exactly SYNC_STAGES edges after first toggle.
//   pend=3, pulse_rdy=1 for 3 cycles, no toggles -> pend 2,1,0; pulse_vld drops with pend=0.
//   pulse_rdy=0, 9 toggles (PEND_W=3) -> pend=7, ovf=1 sticky, evt_cnt=9.
//   pend=7, det coincident with take -> pend stays 7, ovf unchanged, evt_cnt+1.
//   evt_cnt=255 plus one toggle -> evt_cnt=0; with TOGDEC_CLR_EN, clr=1 -> pend=0, ovf=0, evt_cnt=0.

Source files
------------

// File: rtl/tog_pulse_dec.sv
// -----------------------------------------------------------------------------
// tog_pulse_dec
//   Receive end of a toggle-event link. A T flip-flop on the far side flips
//   tog_in once per event. This block synchronises tog_in into CLK and turns
//   each toggle back into one event. Events wait in a saturating pending
//   counter and leave through a valid/ready handshake. A wrapping counter
//   tallies every event that was detected.
//
//   The detector stays in ARMING for SYNC_STAGES+1 edges after reset release.
//   During that time the synchroniser fills with the real line level. As a
//   result, a tog_in that is already high at reset is not taken as an event.
//
//   Limitation: the source must hold each tog_in level for at least two CLK
//   periods. Toggles that are closer together than that may merge and lose
//   an even number of events. The block does not detect this.
//
// Parameters
//   SYNC_STAGES  flops in the tog_in synchroniser (legal 2..4)
//   PEND_W       pending counter width; saturates at 2**PEND_W-1
//   CNT_W        evt_cnt width; wraps modulo 2**CNT_W
//
// Ports
//   CLK        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   clr        in   synchronous counter clear (only with TOGDEC_CLR_EN)
//   tog_in     in   toggle line, asynchronous to CLK
//   pulse_rdy  in   downstream accepts one event; ignored while pend==0
//   pulse_vld  out  at least one event pending (decode of pend)
//   pend       out  number of pending events
//   evt_cnt    out  toggles detected since reset or clear, wrapping
//   ovf        out  sticky: a toggle arrived while pend was saturated
//   armed      out  detector active
//
// Build option
//   TOGDEC_CLR_EN  when defined, adds the clr port. clr clears pend, evt_cnt
//                  and ovf synchronously and takes priority over det and take.
//                  When undefined, only rst clears the counters.
// -----------------------------------------------------------------------------
module tog_pulse_dec #(
  parameter int SYNC_STAGES = 2,
  parameter int PEND_W      = 3,
  parameter int CNT_W       = 8
) (
  input  logic              CLK,
  input  logic              rst,
`ifdef TOGDEC_CLR_EN
  input  logic              clr,
`endif
  input  logic              tog_in,
  input  logic              pulse_rdy,
  output logic              pulse_vld,
  output logic [PEND_W-1:0] pend,
  output logic [CNT_W-1:0]  evt_cnt,
  output logic              ovf,
  output logic              armed
);

  typedef enum logic [0:0] {
    ST_ARMING = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  // The arm counter stops at SYNC_STAGES. The transition to ACTIVE happens
  // on the edge after that, so the total is SYNC_STAGES+1 edges.
  localparam logic [2:0]        ARM_LAST  = 3'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  state_e                 state_q;
  logic [2:0]             arm_cnt_q;
  logic                   armed_q;
  logic [PEND_W-1:0]      pend_q, pend_d;
  logic [CNT_W-1:0]       evt_q, evt_d;
  logic                   ovf_q, ovf_d;
  logic                   det_s;
  logic                   take_s;
  logic                   vld_s;
  logic                   clr_s;

`ifdef TOGDEC_CLR_EN
  assign clr_s = clr;
`else
  assign clr_s = 1'b0;
`endif

  // Synchroniser chain; prev_q holds the chain output from one cycle earlier.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{1'b0}};
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Arming FSM: hold off detection until the chain holds the true line level.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_ARMING;
      arm_cnt_q <= 3'd0;
      armed_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_ARMING: begin
          if (arm_cnt_q == ARM_LAST) begin
            state_q <= ST_ACTIVE;
            armed_q <= 1'b1;
          end else begin
            arm_cnt_q <= arm_cnt_q + 3'd1;
          end
        end
        ST_ACTIVE: begin
          state_q <= ST_ACTIVE;
          armed_q <= 1'b1;
        end
        default: begin
          state_q   <= ST_ARMING;
          arm_cnt_q <= 3'd0;
          armed_q   <= 1'b0;
        end
      endcase
    end
  end

  // Edge detect and handshake decode.
  assign det_s  = (sync_q[SYNC_STAGES-1] ^ prev_q) & (state_q == ST_ACTIVE);
  assign vld_s  = (pend_q != PEND_ZERO);
  assign take_s = vld_s & pulse_rdy;

  // Next-state logic for the pending counter, overflow flag and event tally.
  always_comb begin
    pend_d = pend_q;
    evt_d  = evt_q;
    ovf_d  = ovf_q;
    if (clr_s) begin
      pend_d = PEND_ZERO;
      evt_d  = CNT_ZERO;
      ovf_d  = 1'b0;
    end else begin
      if (det_s) begin
        evt_d = evt_q + CNT_W'(1);
      end else begin
        evt_d = evt_q;
      end
      case ({det_s, take_s})
        2'b10: begin
          if (pend_q == PEND_MAX) begin
            pend_d = pend_q;
            ovf_d  = 1'b1;
          end else begin
            pend_d = pend_q + PEND_W'(1);
          end
        end
        2'b01: begin
          pend_d = pend_q - PEND_W'(1);
        end
        // Arrival and departure in the same cycle cancel, even when saturated.
        default: begin
          pend_d = pend_q;
        end
      endcase
    end
  end

  // Counter and flag registers.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      pend_q <= PEND_ZERO;
      evt_q  <= CNT_ZERO;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      evt_q  <= evt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pulse_vld = vld_s;
  assign pend      = pend_q;
  assign evt_cnt   = evt_q;
  assign ovf       = ovf_q;
  assign armed     = armed_q;

endmodule

// File: tb/tb_tog_pulse_dec.sv
module tb_tog_pulse_dec;

  localparam int SYNC     = 2;
  localparam int PEND_W   = 3;
  localparam int CNT_W    = 8;
  localparam int PEND_MAX = (1 << PEND_W) - 1;
  localparam int CNT_MOD  = 1 << CNT_W;

  logic              CLK = 1'b0;
  logic              rst = 1'b0;
  logic              tog_in = 1'b0;
  logic              pulse_rdy = 1'b0;
`ifdef TOGDEC_CLR_EN
  logic              clr = 1'b0;
`endif
  logic              pulse_vld;
  logic [PEND_W-1:0] pend;
  logic [CNT_W-1:0]  evt_cnt;
  logic              ovf;
  logic              armed;

  tog_pulse_dec #(.SYNC_STAGES(SYNC), .PEND_W(PEND_W), .CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .rst       (rst),
`ifdef TOGDEC_CLR_EN
    .clr       (clr),
`endif
    .tog_in    (tog_in),
    .pulse_rdy (pulse_rdy),
    .pulse_vld (pulse_vld),
    .pend      (pend),
    .evt_cnt   (evt_cnt),
    .ovf       (ovf),
    .armed     (armed)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int pend;
    int evt;
    bit ovf;
    bit armed;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: edges since release, and the line level applied at each edge
  int n_edge;
  bit tin_h[$];
  int m_pend, m_evt;
  bit m_ovf;
  bit cur;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic bit tin_at(input int m);
    if (m <= 0) return 1'b0;
    return tin_h[m-1];
  endfunction

  task automatic model_reset();
    n_edge = 0;
    tin_h.delete();
    m_pend = 0;
    m_evt  = 0;
    m_ovf  = 1'b0;
  endtask

  // Called just after a falling edge. It drives the inputs for the next rising
  // edge, predicts the outputs after that edge, and returns at the next falling edge.
  task automatic step(input bit tog_v, input bit rdy_v, input bit clr_v);
    bit det, take;
    exp_t e;
    tog_in    = tog_v;
    pulse_rdy = rdy_v;
`ifdef TOGDEC_CLR_EN
    clr = clr_v;
`endif
    n_edge++;
    tin_h.push_back(tog_v);
    // A toggle is seen once the detector is armed and the level applied SYNC
    // edges earlier differs from the level applied the edge before that.
    det  = (n_edge >= SYNC + 2) && (tin_at(n_edge - SYNC) != tin_at(n_edge - SYNC - 1));
    take = (m_pend > 0) && rdy_v;
    if (clr_v) begin
      m_pend = 0; m_evt = 0; m_ovf = 1'b0;
    end else begin
      if (det) m_evt = (m_evt + 1) % CNT_MOD;
      if (det && !take) begin
        if (m_pend == PEND_MAX) m_ovf = 1'b1;
        else m_pend++;
      end else if (!det && take) begin
        m_pend--;
      end
    end
    e.pend  = m_pend;
    e.evt   = m_evt;
    e.ovf   = m_ovf;
    e.armed = (n_edge >= SYNC + 1);
    exp_q.push_back(e);
    @(negedge CLK);
  endtask

  // Monitor: pops one expectation per rising edge that has one queued
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pend", int'(pend), e.pend);
        chk("evt_cnt", int'(evt_cnt), e.evt);
        chk("ovf", int'(ovf), int'(e.ovf));
        chk("armed", int'(armed), int'(e.armed));
        chk("pulse_vld", int'(pulse_vld), int'(e.pend != 0));
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pend"}, int'(pend), 0);
    chk({tag, "_evt"}, int'(evt_cnt), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
    chk({tag, "_armed"}, int'(armed), 0);
    chk({tag, "_vld"}, int'(pulse_vld), 0);
  endtask

  initial begin
    int since;
    model_reset();
    rst = 1'b0;
    tog_in = 1'b1;
    repeat (3) @(negedge CLK);
    chk_reset_outputs("rst");
    rst = 1'b1;
    cur = 1'b1;

    // A static high line at reset must not produce an event
    repeat (10) step(cur, 1'b0, 1'b0);

    // Three toggles, four cycles apart, no drain
    repeat (3) begin
      cur = ~cur;
      step(cur, 1'b0, 1'b0);
      repeat (3) step(cur, 1'b0, 1'b0);
    end
    // Drain three events, then idle
    repeat (3) step(cur, 1'b1, 1'b0);
    repeat (2) step(cur, 1'b0, 1'b0);

    // Nine toggles with no drain saturate pend and set ovf
    repeat (9) begin
      cur = ~cur;
      step(cur, 1'b0, 1'b0);
      step(cur, 1'b0, 1'b0);
    end
    repeat (4) step(cur, 1'b0, 1'b0);

    // A detection in the same cycle as a take while saturated
    cur = ~cur;
    step(cur, 1'b0, 1'b0);
    step(cur, 1'b0, 1'b0);
    step(cur, 1'b1, 1'b0);
    step(cur, 1'b0, 1'b0);
    repeat (3) step(cur, 1'b0, 1'b0);

    // Partial drain, then reset mid-operation discards pending events
    repeat (3) step(cur, 1'b1, 1'b0);
    cur = ~cur;
    step(cur, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    rst = 1'b1;

    // Random traffic. The line level is held at least two cycles; evt_cnt wraps.
    since = 2;
    for (int i = 0; i < 3000; i++) begin
      if (since >= 2 && ($urandom % 3) == 0) begin
        cur = ~cur;
        since = 1;
      end else begin
        since++;
      end
      step(cur, 1'($urandom % 4 == 0), 1'b0);
    end

`ifdef TOGDEC_CLR_EN
    repeat (12) begin
      cur = ~cur;
      step(cur, 1'b0, 1'b0);
      step(cur, 1'b0, 1'b0);
    end
    step(cur, 1'b0, 1'b1);
    repeat (4) step(cur, 1'b0, 1'b0);
`endif

    repeat (2) @(negedge CLK);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
